ahb_sram: RTL and testbench

Parametrised, clocked AHB-style on-chip SRAM slave, successor to the current combinational instruction RAM. It adds a proper address/data pipeline, sized byte-lane writes, programmable wait states and an AHB ERROR response for illegal accesses. It sits on the core's memory bus at a configurable base address and serves both instruction fetches and data loads/stores.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_sram_strobe.sv | 23 ++
 rtl/ahb_sram.sv | 127 ++++++++++++
 tb/tb_ahb_sram.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the SRAM slave's FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

endpackage

// File: rtl/ahb_sram_strobe.sv
// Byte-lane strobe and misalignment decode for one address phase.
module ahb_sram_strobe #(
  parameter int  DATA_W = 64,
  localparam int NB     = DATA_W / 8,
  localparam int LB     = $clog2(NB)
) (
  input  logic [2:0]    hsize,
  input  logic [LB-1:0] addr_lo,
  output logic [NB-1:0] mask,
  output logic          misalign
);

  logic [8:0] nbytes;

  always_comb begin
    nbytes   = 9'd1 << hsize;
    misalign = (32'(hsize) > LB) || ((9'(addr_lo) & (nbytes - 9'd1)) != 9'd0);
    mask     = '0;
    for (int i = 0; i < NB; i++)
      mask[i] = !misalign && (9'(i) >= 9'(addr_lo)) && (9'(i) < 9'(addr_lo) + nbytes);
  end

endmodule

// File: rtl/ahb_sram.sv
// Clocked AHB SRAM slave: address/data pipeline, byte-lane writes,
// programmable wait states and a two-cycle ERROR response.
module ahb_sram
  import ahb_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter int          RAM_BYTES   = 256,
  parameter logic [63:0] RAM_START   = 64'h1000,
  parameter int          WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [63:0]       HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int         NB    = DATA_W / 8;
  localparam int         LB    = $clog2(NB);
  localparam int         WORDS = RAM_BYTES / NB;
  localparam int         IW    = $clog2(WORDS);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  sram_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NB-1:0]     mask_q, mask_d;
  logic [DATA_W-1:0] mem_q [WORDS];

  logic          accept, legal, misalign, commit;
  logic [NB-1:0] strb;
  logic [64:0]   end_addr;

  ahb_sram_strobe #(.DATA_W(DATA_W)) u_strobe (
    .hsize    (HSIZE),
    .addr_lo  (HADDR[LB-1:0]),
    .mask     (strb),
    .misalign (misalign)
  );

  // 65-bit end address so a transfer near 2^64 cannot wrap into range
  assign end_addr = {1'b0, HADDR} + (65'd1 << HSIZE);
  assign legal    = (HADDR >= RAM_START) && !misalign &&
                    (end_addr <= {1'b0, RAM_START} + 65'(RAM_BYTES));
  assign accept   = HSEL && HREADYOUT &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    commit  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else begin
          commit  = write_q;
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: ;
    endcase
    // A completing cycle may also take the next address phase
    if (accept) begin
      write_d = HWRITE;
      idx_d   = IW'((HADDR - RAM_START) >> LB);
      mask_d  = strb;
      state_d = legal ? ST_WAIT : ST_ERR1;
      cnt_d   = legal ? WS : 4'd0;
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (state_q)
      ST_WAIT: begin
        HREADYOUT = (cnt_q == 4'd0);
        if (!write_q) HRDATA = mem_q[idx_q];
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      for (int w = 0; w < WORDS; w++) mem_q[w] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NB; i++)
        if (mask_q[i]) mem_q[idx_q][i*8 +: 8] <= HWDATA[i*8 +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_sram.sv
// Directed bench: a zero-wait instance and a three-wait-state instance
// share the bus, selected by their own HSEL.
module tb_ahb_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel0, hsel1;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] haddr, hwdata;
  logic [63:0] hrdata0, hrdata1;
  logic        hready0, hready1, hresp0, hresp1;

  int          dsel;
  logic [63:0] cur_rdata;
  logic        cur_ready, cur_resp;

  int nvec = 0;
  int nmiss = 0;

  always #5 clk = ~clk;

  ahb_sram #(.DATA_W(64), .RAM_BYTES(256), .RAM_START(64'h1000), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst_n), .HSEL(hsel0), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata0),
    .HREADYOUT(hready0), .HRESP(hresp0));

  ahb_sram #(.DATA_W(64), .RAM_BYTES(256), .RAM_START(64'h1000), .WAIT_STATES(3)) u1 (
    .HCLK(clk), .HRESET(rst_n), .HSEL(hsel1), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata1),
    .HREADYOUT(hready1), .HRESP(hresp1));

  always_comb begin
    cur_rdata = (dsel == 1) ? hrdata1 : hrdata0;
    cur_ready = (dsel == 1) ? hready1 : hready0;
    cur_resp  = (dsel == 1) ? hresp1  : hresp0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmiss++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single transfer; returns data/resp at the completing cycle plus the
  // number of HREADYOUT-low data-phase cycles seen.
  task automatic xfer(input int d, input logic wr, input logic [2:0] sz,
                      input logic [63:0] a, input logic [63:0] wd,
                      output logic [63:0] rd, output logic rfirst,
                      output logic rlast, output int lows);
    dsel = d; hsel0 = (d == 0); hsel1 = (d == 1);
    htrans = 2'b10; hwrite = wr; hsize = sz; haddr = a;
    @(posedge clk); #1;
    htrans = 2'b00; hsel0 = 1'b0; hsel1 = 1'b0; hwdata = wd;
    lows = 0;
    @(negedge clk);
    rfirst = cur_resp;
    while (!cur_ready && lows < 50) begin lows++; @(negedge clk); end
    rd = cur_rdata; rlast = cur_resp;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [63:0] a;
  } err_vec_t;

  initial begin
    logic [63:0] rd;
    logic        rf, rl;
    int          lows;
    err_vec_t    errs [5];
    errs[0] = '{1'b0, 3'd3, 64'h0FF8};
    errs[1] = '{1'b0, 3'd3, 64'h1100};
    errs[2] = '{1'b0, 3'd1, 64'h1001};
    errs[3] = '{1'b1, 3'd1, 64'h1001};
    errs[4] = '{1'b1, 3'd0, 64'h1100};

    dsel = 0; rst_n = 1'b0; hsel0 = 0; hsel1 = 0; htrans = 0; hwrite = 0;
    hsize = 0; haddr = 0; hwdata = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready0", 64'(hready0), 64'd1);
    chk("rst_resp0",  64'(hresp0),  64'd0);
    chk("rst_rdata0", hrdata0,      64'd0);
    chk("rst_ready1", 64'(hready1), 64'd1);
    chk("rst_resp1",  64'(hresp1),  64'd0);
    chk("rst_rdata1", hrdata1,      64'd0);
    @(posedge clk); #1;

    xfer(0, 1'b1, 3'd3, 64'h1000, 64'h1122334455667788, rd, rf, rl, lows);
    chk("wr_dw_lows", 64'(lows), 64'd0);
    chk("wr_dw_resp", 64'(rl), 64'd0);
    chk("wr_rdata_zero", rd, 64'd0);
    xfer(0, 1'b0, 3'd3, 64'h1000, 64'h0, rd, rf, rl, lows);
    chk("rd_dw_data", rd, 64'h1122334455667788);
    chk("rd_dw_resp", 64'(rl), 64'd0);
    chk("rd_dw_lows", 64'(lows), 64'd0);

    xfer(0, 1'b1, 3'd0, 64'h1003, 64'hFFFFFFFFAAFFFFFF, rd, rf, rl, lows);
    xfer(0, 1'b0, 3'd3, 64'h1000, 64'h0, rd, rf, rl, lows);
    chk("rd_after_byte", rd, 64'h11223344AA667788);

    xfer(0, 1'b1, 3'd2, 64'h1004, 64'hDEADBEEFFFFFFFFF, rd, rf, rl, lows);
    xfer(0, 1'b0, 3'd3, 64'h1000, 64'h0, rd, rf, rl, lows);
    chk("rd_after_word", rd, 64'hDEADBEEFAA667788);

    xfer(0, 1'b1, 3'd1, 64'h1006, 64'h1234FFFFFFFFFFFF, rd, rf, rl, lows);
    xfer(0, 1'b0, 3'd2, 64'h1004, 64'h0, rd, rf, rl, lows);
    chk("rd_after_half", rd, 64'h1234BEEFAA667788);

    foreach (errs[k]) begin
      xfer(0, errs[k].wr, errs[k].sz, errs[k].a, 64'hFFFFFFFFFFFFFFFF, rd, rf, rl, lows);
      chk($sformatf("err%0d_lows", k),  64'(lows), 64'd1);
      chk($sformatf("err%0d_resp1", k), 64'(rf),   64'd1);
      chk($sformatf("err%0d_resp2", k), 64'(rl),   64'd1);
      chk($sformatf("err%0d_rdata", k), rd,        64'd0);
    end
    xfer(0, 1'b0, 3'd3, 64'h1000, 64'h0, rd, rf, rl, lows);
    chk("rd_after_errs", rd, 64'h1234BEEFAA667788);
    chk("rd_after_errs_resp", 64'(rl), 64'd0);

    xfer(0, 1'b1, 3'd3, 64'h10F8, 64'hCAFEF00D0BADBEEF, rd, rf, rl, lows);
    chk("wr_top_resp", 64'(rl), 64'd0);
    xfer(0, 1'b0, 3'd3, 64'h10F8, 64'h0, rd, rf, rl, lows);
    chk("rd_top_data", rd, 64'hCAFEF00D0BADBEEF);
    @(negedge clk);
    chk("idle_rdata", hrdata0, 64'd0);
    chk("idle_ready", 64'(hready0), 64'd1);
    @(posedge clk); #1;

    // Back-to-back write then read on the wait-state instance
    dsel = 1; hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd3; haddr = 64'h1010;
    @(posedge clk); #1;
    hwdata = 64'h0123456789ABCDEF; hwrite = 1'b0;
    lows = 0;
    @(negedge clk);
    while (!cur_ready && lows < 50) begin lows++; @(negedge clk); end
    chk("b2b_wr_lows", 64'(lows), 64'd3);
    @(posedge clk); #1;
    htrans = 2'b00; hsel1 = 1'b0;
    lows = 0;
    @(negedge clk);
    while (!cur_ready && lows < 50) begin lows++; @(negedge clk); end
    chk("b2b_rd_lows", 64'(lows), 64'd3);
    chk("b2b_rd_data", cur_rdata, 64'h0123456789ABCDEF);
    chk("b2b_rd_resp", 64'(cur_resp), 64'd0);
    @(posedge clk); #1;

    // Reset during a wait cycle of a write
    hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd3; haddr = 64'h1020;
    @(posedge clk); #1;
    htrans = 2'b00; hsel1 = 1'b0; hwdata = 64'h5555AAAA5555AAAA;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(hready1), 64'd1);
    chk("mid_rst_resp",  64'(hresp1),  64'd0);
    chk("mid_rst_rdata", hrdata1,      64'd0);
    @(posedge clk); #1;
    xfer(1, 1'b0, 3'd3, 64'h1020, 64'h0, rd, rf, rl, lows);
    chk("rst_abort_rd", rd, 64'd0);
    chk("rst_abort_lows", 64'(lows), 64'd3);
    xfer(1, 1'b0, 3'd3, 64'h1010, 64'h0, rd, rf, rl, lows);
    chk("rst_cleared_1010", rd, 64'd0);
    xfer(0, 1'b0, 3'd3, 64'h1000, 64'h0, rd, rf, rl, lows);
    chk("rst_cleared_dut0", rd, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
